// File: rtl/dmem_responder_if.sv
// Data-port bus between the core (master) and the data memory responder (slave).
// The core holds MemWrite/MemRead until it sees Ready.
interface dmem_responder_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Error;

    modport master (
        output MemWrite, MemRead, DataAdr, WriteData, ByteEn,
        input  ReadData, Ready, Error
    );

    modport slave (
        input  MemWrite, MemRead, DataAdr, WriteData, ByteEn,
        output ReadData, Ready, Error
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a multi-cycle Ready handshake.
// Each request goes IDLE -> WAIT (WAIT_STATES cycles) -> ACK (one Ready cycle).
// Illegal accesses (misaligned, out of range, read+write together) still get a
// Ready, but with Error set, no RAM update and no write count.
// Optional: DMEM_DONE_DETECT_EN adds a sticky Done flag, set by a full-word
// write of DONE_DATA to byte address DONE_ADDR. Without it Done is tied low.
module dmem_responder #(
    parameter int          ADDR_WIDTH  = 6,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] DONE_ADDR   = 32'd100,
    parameter logic [31:0] DONE_DATA   = 32'd7
) (
    input  logic                clk,
    input  logic                reset,
    dmem_responder_if.slave     bus,
    output logic [15:0]         WriteCount,
    output logic                Done
);
    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                  state, state_next;
    logic                    accept;
    logic                    ack;
    logic                    req_illegal;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [3:0]              ben_q;
    logic                    write_q;
    logic                    illegal_q;
    logic                    commit;
    logic                    read_ok;
    logic [31:0]             rdata_q;
    logic [31:0]             rdata_out;
    logic [31:0]             mem [DEPTH];

    // Illegal if misaligned, beyond the RAM, or both read and write requested.
    assign req_illegal = (bus.DataAdr[1:0] != 2'b00)
                       || ((bus.DataAdr >> (ADDR_WIDTH + 2)) != 32'd0)
                       || (bus.MemWrite && bus.MemRead);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode: accept in IDLE, count down in WAIT, single ACK cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack        = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.MemWrite || bus.MemRead) begin
                    accept     = 1'b1;
                    state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_next = S_ACK;
            end
            S_ACK: begin
                ack        = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A reset landing on the ACK cycle suppresses the acknowledge and the commit.
    assign commit  = ack && !reset && write_q && !illegal_q;
    assign read_ok = ack && !write_q && !illegal_q;

    assign bus.Ready = ack && !reset;
    assign bus.Error = ack && !reset && illegal_q;

    // ReadData is live in ACK (zero unless a legal read) and held otherwise.
    assign rdata_out    = ack ? (read_ok ? mem[idx_q] : 32'd0) : rdata_q;
    assign bus.ReadData = rdata_out;

    // Capture the request at acceptance and run the wait-state counter.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q     <= bus.DataAdr[ADDR_WIDTH+1:2];
            wdata_q   <= bus.WriteData;
            ben_q     <= bus.ByteEn;
            write_q   <= bus.MemWrite;
            illegal_q <= req_illegal;
            wait_cnt  <= WAIT_LOAD;
        end else if (state == S_WAIT && wait_cnt != 4'd0) begin
            wait_cnt  <= wait_cnt - 4'd1;
        end
    end

    // RAM write, byte-lane masked; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (commit && ben_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
    end

    // Hold the last acknowledged read value for the IDLE/WAIT cycles.
    always_ff @(posedge clk) begin
        if (reset)    rdata_q <= 32'd0;
        else if (ack) rdata_q <= rdata_out;
    end

    // Committed-write counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset)                              WriteCount <= 16'd0;
        else if (commit && WriteCount != 16'hFFFF) WriteCount <= WriteCount + 16'd1;
    end

`ifdef DMEM_DONE_DETECT_EN
    logic done_match_q;

    // Evaluate the done pattern at acceptance so only one flag bit is kept.
    always_ff @(posedge clk) begin
        if (accept) done_match_q <= (bus.DataAdr == DONE_ADDR) && (bus.ByteEn == 4'hF)
                                 && (bus.WriteData == DONE_DATA);
    end

    // Sticky done flag, set when the matching write commits.
    always_ff @(posedge clk) begin
        if (reset)                      Done <= 1'b0;
        else if (commit && done_match_q) Done <= 1'b1;
    end
`else
    assign Done = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes the expected
// response of each request from a word-array model; a monitor pops on Ready.
// A second instance with WAIT_STATES=0 covers the held-request cadence.
module tb_dmem_responder;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wcnt, wcnt0;
    logic        done, done0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    dmem_responder_if bus();
    dmem_responder_if bus0();

    dmem_responder #(.WAIT_STATES(W)) dut (
        .clk(clk), .reset(rst), .bus(bus), .WriteCount(wcnt), .Done(done)
    );

    dmem_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst), .bus(bus0), .WriteCount(wcnt0), .Done(done0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        is_read;
        int          cyc;
        logic [15:0] cnt;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [64];
    int          cnt_m = 0;
    logic        done_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        else n_pass++;
    endtask

    // Reference model: apply one request to the word array and predict the response.
    task automatic model(input logic we, input logic re, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [3:0] be, output exp_t e);
        logic ill;
        int   idx;
        ill = (adr % 4 != 0) || (adr >= 256) || (we && re);
        idx = adr / 4;
        e.err = ill;
        e.is_read = re && !we;
        e.rdata = 32'd0;
        if (!ill && we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
            if (cnt_m < 65535) cnt_m++;
`ifdef DMEM_DONE_DETECT_EN
            if (adr == 100 && be == 4'hF && wd == 7) done_m = 1'b1;
`endif
        end
        if (!ill && !we) e.rdata = mem_m[idx];
        e.cnt = 16'(cnt_m);
        e.done = done_m;
    endtask

    // Issue one request at a negedge, wait (bounded) for Ready, drop it in the ACK cycle.
    task automatic access(input logic we, input logic re, input logic [31:0] adr,
                          input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        bit   seen = 0;
        model(we, re, adr, wd, be, e);
        e.cyc = cyc + W + 1;
        sb.push_back(e);
        bus.MemWrite = we; bus.MemRead = re;
        bus.DataAdr = adr; bus.WriteData = wd; bus.ByteEn = be;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.Ready) seen = 1;
        end
        if (!seen) chk("ready_timeout", 32'd0, 32'd1);
        bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compare each acknowledge against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.Ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("error", {31'd0, bus.Error}, {31'd0, e.err});
                    if (e.is_read) chk("read_data", bus.ReadData, e.rdata);
                    @(negedge clk);
                    chk("write_count", {16'd0, wcnt}, {16'd0, e.cnt});
                    chk("done", {31'd0, done}, {31'd0, e.done});
                    if (e.is_read) chk("read_hold", bus.ReadData, e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [31:0] a;
        bus.MemWrite = 0; bus.MemRead = 0; bus.DataAdr = 0; bus.WriteData = 0; bus.ByteEn = 0;
        bus0.MemWrite = 0; bus0.MemRead = 0; bus0.DataAdr = 0; bus0.WriteData = 0; bus0.ByteEn = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.Ready}, 32'd0);
        chk("rst_error", {31'd0, bus.Error}, 32'd0);
        chk("rst_rdata", bus.ReadData, 32'd0);
        chk("rst_wcount", {16'd0, wcnt}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Basic write/read and byte-lane merge.
        access(1, 0, 32'h20, 32'h12345678, 4'hF);
        access(0, 1, 32'h20, 32'h0, 4'h0);
        access(1, 0, 32'h24, 32'hFFFFFFFF, 4'hF);
        access(1, 0, 32'h24, 32'h000000AA, 4'b0001);
        access(0, 1, 32'h24, 32'h0, 4'h0);
        chk("lane_model", mem_m[9], 32'hFFFFFFAA);
        access(1, 0, 32'h28, 32'hDEADBEEF, 4'h0);

        // Fill every word so later reads are defined.
        for (int i = 0; i < 64; i++) access(1, 0, 32'(i * 4), $urandom, 4'hF);

        // Illegal accesses, then read back the aliased words.
        access(1, 0, 32'h22, 32'hCAFEF00D, 4'hF);
        access(1, 0, 32'h100, 32'hCAFEF00D, 4'hF);
        access(1, 1, 32'h30, 32'hCAFEF00D, 4'hF);
        access(0, 1, 32'h20, 32'h0, 4'h0);
        access(0, 1, 32'h00, 32'h0, 4'h0);
        access(0, 1, 32'h30, 32'h0, 4'h0);
        access(0, 1, 32'h31, 32'h0, 4'h0);

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 63) * 4);
            if (r < 4)       access(0, 1, a, 32'h0, 4'h0);
            else if (r < 8)  access(1, 0, a, $urandom, 4'($urandom));
            else if (r == 8) access(r[0], !r[0], a | 32'($urandom_range(1, 3)), $urandom, 4'hF);
            else             access(1, $urandom_range(0, 1) == 1, a | 32'h100, $urandom, 4'hF);
        end

        // Done detector: near miss, then the matching write.
        access(1, 0, 32'd96, 32'd7, 4'hF);
        access(1, 0, 32'd100, 32'd7, 4'hE);
        access(1, 0, 32'd100, 32'd7, 4'hF);
        access(0, 1, 32'd100, 32'h0, 4'h0);

        // Zero wait states: a held write acknowledges every second cycle.
        bus0.MemWrite = 1; bus0.DataAdr = 32'h08; bus0.WriteData = 32'hA5A5A5A5; bus0.ByteEn = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("ws0_ready", {31'd0, bus0.Ready}, {31'd0, 1'(k % 2)});
        end
        bus0.MemWrite = 0;
        chk("ws0_count", {16'd0, wcnt0}, 32'd4);

        // Reset during WAIT of a write: no Ready, no commit, count cleared.
        bus.MemWrite = 1; bus.DataAdr = 32'h40; bus.WriteData = 32'h55; bus.ByteEn = 4'hF;
        @(negedge clk);
        bus.MemWrite = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt_m = 0;
        done_m = 1'b0;
        chk("midrst_count", {16'd0, wcnt}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);
        access(0, 1, 32'h40, 32'h0, 4'h0);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
